uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts a parallel byte through a valid/ready handshake and serialises it as one frame: start bit, data bits LSB first, optional parity bit, one stop bit. An internal divider generates the bit timing from sys_clk. The block drives the serial line idle-high.

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; DIV = CLK_FREQ/BAUD_RATE (integer division, DIV >= 2 required)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 1, 1 = parity bit inserted after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
sys_clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  byte to transmit; sampled only on handshake
tx_valid  input  1  request to send tx_data
tx_ready  output  1  block can accept a new byte
serial_data_out  output  1  UART line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset (rst=1 at a clock edge): serial_data_out=1, busy=0, tx_ready=1, tx_done=0, state=IDLE, divider=0, bit index=0.
- Reset mid-frame: the frame is abandoned and the line returns high on the next edge. No tx_done pulse.
- Handshake: the block accepts when tx_valid && tx_ready at a clock edge. It latches tx_data into a shift register and computes parity from the latched value.
  - tx_valid while tx_ready=0 is ignored; no queuing.
  - tx_data changes after acceptance do not affect the frame in flight.
- FSM states and transitions:
  - IDLE: line=1, tx_ready=1, busy=0. On accept, go to START; divider cleared.
  - START: line=0 for DIV cycles, then DATA with bit index=0.
  - DATA: line=shift_reg[0] for DIV cycles per bit, then shift right and increment index. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: line=^data for even parity, ~^data for odd parity, for DIV cycles, then STOP.
  - STOP: line=1 for DIV cycles. On its final cycle, tx_done=1; next state IDLE.
- Timing:
  - Line changes to 0 on the edge after acceptance.
  - Every bit lasts exactly DIV sys_clk cycles.
  - Frame length = (1 + DATA_BITS + PARITY_EN + 1) * DIV cycles.
- Outputs: busy=1 and tx_ready=0 in all states other than IDLE; tx_ready returns to 1 on the cycle after tx_done.
  - Back-to-back: holding tx_valid=1 starts the next frame on the first IDLE cycle, giving exactly one idle cycle (line=1) between frames.
- Divider counts 0..DIV-1 and is restarted at acceptance, so bit edges are phase-locked to the frame start rather than free-running.
- serial_data_out, busy, tx_ready and tx_done are registered outputs (glitch-free).

Test Plan:
- Params CLK_FREQ=160, BAUD_RATE=10 (DIV=16), 8 bits, even parity. Pulse tx_valid with tx_data=0xA5 -> line low for 16 cycles; data bits 1,0,1,0,0,1,0,1 at 16 cycles each; parity 0; stop 1. tx_done pulses at cycle 176 after accept; busy high for 176 cycles.
- Same params, tx_data=0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. With PARITY_EN=0 -> no parity slot, frame length 160 cycles.
- Change tx_data and pulse tx_valid mid-frame -> request ignored, tx_ready stays 0, transmitted bits match the originally latched byte.
- tx_valid held high with 0x55 then 0xAA -> two complete frames separated by exactly one idle-high cycle; two tx_done pulses 177 cycles apart.
- Assert rst during data bit 3 -> next edge: line=1, busy=0, tx_ready=1, no tx_done. A new request afterwards produces a clean full frame.
- DATA_BITS=5, tx_data=5'b10011, even parity -> data bits 1,1,0,0,1 then parity 1; frame length 8*DIV.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmitter, one frame per accepted byte.
//
// Frame on the line: start (0), DATA_BITS data bits LSB first, optional
// parity bit, one stop bit (1). Every bit lasts DIV = CLK_FREQ/BAUD_RATE
// sys_clk cycles. The divider restarts at acceptance, so bit edges are
// locked to the frame start.
//
// Ports:
//   sys_clk          system clock, rising edge
//   rst              synchronous reset, active high
//   tx_data          byte to send, sampled only on the handshake
//   tx_valid         request to send tx_data
//   tx_ready         high when a new byte can be accepted (registered)
//   serial_data_out  UART line, idle high (registered)
//   busy             frame in progress (registered)
//   tx_done          one-cycle pulse on the final cycle of the stop bit
module uart_tx_frame #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 serial_data_out,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int DIV = CLK_FREQ / BAUD_RATE;
   localparam int DW  = $clog2(DIV);
   localparam int IW  = $clog2(DATA_BITS);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_PEN  = DW'(DIV - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic          PAR_ODD  = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 r_state;
   logic [DW-1:0]          r_div;
   logic [IW-1:0]          r_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par;
   logic                   r_line;
   logic                   r_busy;
   logic                   r_ready;
   logic                   r_done;

   logic                   w_bit_end;

   assign w_bit_end       = (r_div == DIV_LAST);
   assign serial_data_out = r_line;
   assign busy            = r_busy;
   assign tx_ready        = r_ready;
   assign tx_done         = r_done;

   // Outputs are registered, so each transition loads the line value of
   // the slot being entered rather than the one being left.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_line  <= 1'b1;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != S_IDLE)
            r_div <= w_bit_end ? '0 : r_div + 1'b1;

         case (r_state)
            S_IDLE: begin
               r_line  <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               if (tx_valid && r_ready) begin
                  r_shift <= tx_data;
                  r_par   <= (^tx_data) ^ PAR_ODD;
                  r_div   <= '0;
                  r_idx   <= '0;
                  r_line  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
                  r_idx   <= '0;
                  r_line  <= r_shift[0];
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  if (r_idx == IDX_LAST) begin
                     if (PARITY_EN != 0) begin
                        r_state <= S_PARITY;
                        r_line  <= r_par;
                     end else begin
                        r_state <= S_STOP;
                        r_line  <= 1'b1;
                     end
                  end else begin
                     // bit [1] is the next LSB once this shift lands
                     r_shift <= r_shift >> 1;
                     r_idx   <= r_idx + 1'b1;
                     r_line  <= r_shift[1];
                  end
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_line  <= 1'b1;
               end
            end

            S_STOP: begin
               // set one edge early so the pulse sits on the last stop cycle
               if (r_div == DIV_PEN)
                  r_done <= 1'b1;
               if (w_bit_end) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_line  <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances with DIV=16 cover even,
// odd, no parity and 5-bit frames. Each frame is walked cycle by cycle
// against a slot model built from the byte and the hand-computed parity.
module tb_uart_tx_frame;

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] data [4];
   logic [3:0] valid   = '0;
   logic [3:0] ser, bsy, rdy, dn;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int done_a, done_b;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // 0: 8 bits even, 1: 8 bits odd, 2: 8 bits no parity, 3: 5 bits even
   uart_tx_frame #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8),
                   .PARITY_EN(1), .PARITY_ODD(0)) u_a (
      .sys_clk(sys_clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
      .tx_ready(rdy[0]), .serial_data_out(ser[0]), .busy(bsy[0]), .tx_done(dn[0]));
   uart_tx_frame #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8),
                   .PARITY_EN(1), .PARITY_ODD(1)) u_b (
      .sys_clk(sys_clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
      .tx_ready(rdy[1]), .serial_data_out(ser[1]), .busy(bsy[1]), .tx_done(dn[1]));
   uart_tx_frame #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8),
                   .PARITY_EN(0), .PARITY_ODD(0)) u_c (
      .sys_clk(sys_clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
      .tx_ready(rdy[2]), .serial_data_out(ser[2]), .busy(bsy[2]), .tx_done(dn[2]));
   uart_tx_frame #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(5),
                   .PARITY_EN(1), .PARITY_ODD(0)) u_d (
      .sys_clk(sys_clk), .rst(rst), .tx_data(data[3][4:0]), .tx_valid(valid[3]),
      .tx_ready(rdy[3]), .serial_data_out(ser[3]), .busy(bsy[3]), .tx_done(dn[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a byte; returns just after the accepting edge (frame cycle 0).
   task automatic send(input int d, input logic [7:0] b, input bit hold);
      @(negedge sys_clk);
      data[d]  = b;
      valid[d] = 1'b1;
      @(posedge sys_clk);
      #1;
      if (!hold) valid[d] = 1'b0;
   endtask

   // Walk frame cycles 0..frame (the last one is the idle cycle after it).
   // inj=1: pulse tx_valid with new data mid-frame; inj=2: change data only.
   task automatic check_frame(input int d, input logic [7:0] b, input int nb,
                              input bit pe, input bit pb, input int inj,
                              input logic [7:0] inj_d);
      int   frame;
      int   slot;
      logic el;
      frame = (2 + nb + (pe ? 1 : 0)) * 16;
      for (int k = 0; k <= frame; k++) begin
         @(negedge sys_clk);
         slot = k / 16;
         if (k == frame)                 el = 1'b1;
         else if (slot == 0)             el = 1'b0;
         else if (slot <= nb)            el = b[slot-1];
         else if (pe && slot == nb + 1)  el = pb;
         else                            el = 1'b1;
         chk($sformatf("line d%0d k%0d", d, k), 32'(ser[d]), 32'(el));
         chk($sformatf("busy d%0d k%0d", d, k), 32'(bsy[d]), 32'(k < frame));
         chk($sformatf("rdy d%0d k%0d", d, k), 32'(rdy[d]), 32'(k == frame));
         chk($sformatf("done d%0d k%0d", d, k), 32'(dn[d]), 32'(k == frame - 1));
         if (dn[d]) begin
            done_a = done_b;
            done_b = cyc;
         end
         if (inj != 0 && k == 40) begin
            data[d] = inj_d;
            if (inj == 1) valid[d] = 1'b1;
         end
         if (inj == 1 && k == 41) valid[d] = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) data[i] = 8'h00;
      done_a = -1;
      done_b = -1;

      // reset state on all instances
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst line", 32'(ser), 32'hF);
      chk("rst busy", 32'(bsy), 32'h0);
      chk("rst rdy",  32'(rdy), 32'hF);
      chk("rst done", 32'(dn),  32'h0);
      rst = 1'b0;

      // 0xA5 even parity: 4 ones -> parity 0, 176-cycle frame
      send(0, 8'hA5, 1'b0);
      check_frame(0, 8'hA5, 8, 1'b1, 1'b0, 0, 8'h00);

      // 0x07 even -> parity 1; mid-frame request with new data is ignored
      send(0, 8'h07, 1'b0);
      check_frame(0, 8'h07, 8, 1'b1, 1'b1, 1, 8'hF0);

      // 0x07 odd -> parity 0
      send(1, 8'h07, 1'b0);
      check_frame(1, 8'h07, 8, 1'b1, 1'b0, 0, 8'h00);

      // 0x07 without parity -> 160-cycle frame
      send(2, 8'h07, 1'b0);
      check_frame(2, 8'h07, 8, 1'b0, 1'b0, 0, 8'h00);

      // 5-bit 10011 even -> bits 1,1,0,0,1, parity 1, 128-cycle frame
      send(3, 8'h13, 1'b0);
      check_frame(3, 8'h13, 5, 1'b1, 1'b1, 0, 8'h00);

      // back-to-back with tx_valid held: one idle cycle, done pulses 177 apart
      done_a = -1;
      done_b = -1;
      send(0, 8'h55, 1'b1);
      check_frame(0, 8'h55, 8, 1'b1, 1'b0, 2, 8'hAA);
      @(posedge sys_clk);
      #1;
      valid[0] = 1'b0;
      check_frame(0, 8'hAA, 8, 1'b1, 1'b0, 0, 8'h00);
      chk("b2b done gap", 32'(done_b - done_a), 32'd177);

      // reset during data bit 3 (frame cycle 72)
      send(0, 8'hC3, 1'b0);
      repeat (72) @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge sys_clk);
         chk($sformatf("post-rst line k%0d", k), 32'(ser[0]), 32'd1);
         chk($sformatf("post-rst busy k%0d", k), 32'(bsy[0]), 32'd0);
         chk($sformatf("post-rst rdy k%0d", k),  32'(rdy[0]), 32'd1);
         chk($sformatf("post-rst done k%0d", k), 32'(dn[0]),  32'd0);
      end
      // clean frame after the reset: 0x3C has 4 ones -> parity 0
      send(0, 8'h3C, 1'b0);
      check_frame(0, 8'h3C, 8, 1'b1, 1'b0, 0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
